input_controller: RTL and testbench
===================================

Name: input_controller

Overview:
- Per-port input controller sitting directly downstream of the router input FIFO.
- Pops one flit at a time from the FIFO via its request/grant handshake and decodes the destination with XY routing.
- Requests the chosen output port from the switch allocator and, once granted, drives the flit into the crossbar for exactly one cycle.

Parameters:
- dataWidth, 32, flit width in bits.
- dim, 2, width of each destination X/Y field.
- curX, 1, this router's X coordinate (dim bits).
- curY, 1, this router's Y coordinate (dim bits).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- fifoEmpty  input  1  empty flag from the upstream FIFO.
- reqFifo  output  1  read request to the FIFO.
- gntFifo  input  1  read grant from the FIFO; PacketIn is valid in the same cycle.
- PacketIn  input  dataWidth  flit from the FIFO.
- reqSw  output  5  one-hot output-port request to the switch allocator.
- gntSw  input  5  grant from the switch allocator.
- PacketOut  output  dataWidth  flit to the crossbar.
- validOut  output  1  PacketOut qualifier.

Interface rule: one clock; reset is synchronous and active-high, port names clk and reset.

Behaviour:
- Flit fields:
  - destX = PacketIn[dataWidth-1 -: dim].
  - destY = PacketIn[dataWidth-1-dim -: dim].
  - Comparisons are unsigned.
- Port bit order in reqSw/gntSw: 0 Local, 1 North, 2 East, 3 South, 4 West.
- XY routing:
  - destX>curX -> East; destX<curX -> West.
  - Otherwise destY>curY -> North; destY<curY -> South.
  - Otherwise Local.
  - The route is always exactly one-hot.
- All outputs are registered (Moore). FSM states: IDLE, REQ, WAIT, ROUTE, ARB, SEND.
  - IDLE: if !fifoEmpty -> REQ.
  - REQ: reqFifo=1 for exactly one cycle -> WAIT. A single-cycle pulse guarantees one pop per packet.
  - WAIT: if gntFifo, latch PacketIn into flitReg -> ROUTE. If not, -> IDLE (no retry stall, no data latched).
  - ROUTE: compute and register the one-hot route -> ARB.
  - ARB: reqSw=route, held until (gntSw & route)!=0, then -> SEND.
    - Grant bits not matching the route are ignored.
    - Extra set bits in gntSw are ignored.
  - SEND: reqSw=0, validOut=1, PacketOut=flitReg for one cycle -> IDLE.
- Latency:
  - Minimum 5 cycles from the first cycle fifoEmpty=0 in IDLE to validOut=1 (REQ c1, WAIT c2, ROUTE c3, ARB c4, SEND c5).
  - Each extra cycle of waiting for the allocator grant adds one cycle.
- Throughput: at most one flit per 6 cycles. No overlap between packets.
- PacketOut holds its last value when validOut=0. It is only meaningful when validOut=1.
- Reset (any state, including mid-ARB or mid-SEND):
  - Next cycle: state=IDLE; reqFifo=0, reqSw=0, validOut=0, PacketOut=0, flitReg=0.
  - A flit already popped but not sent is dropped.
- fifoEmpty rising while in REQ: no special handling. The FIFO returns no grant, so WAIT falls back to IDLE.

Optional Feature:
- Macro: INCTR_STATS_EN.
- Defined:
  - Adds output pktCount [15:0], reset to 0.
  - Increments by 1 in every SEND cycle and wraps 0xFFFF -> 0x0000.
  - Adds output stallCycles [15:0], reset to 0. Increments in every ARB cycle without a matching grant; saturates at 0xFFFF.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Shared package noc_pkg holds:
  - port index constants PORT_L=0, PORT_N=1, PORT_E=2, PORT_S=3, PORT_W=4, and NUM_PORTS=5;
  - the FSM state encoding typedef;
  - field-extraction helpers for destX/destY.
- One natural sub-module: xy_route_calc. Purely combinational; takes destX, destY, curX, curY and returns the 5-bit one-hot route. It is reused by every input port.

Test Plan:
- curX=curY=1, FIFO model returns 0xC000_0000, gntSw=5'b11111 immediately.
  - Expect reqSw=5'b00100 (East).
  - Expect validOut=1 with PacketOut=0xC000_0000 exactly 5 cycles after fifoEmpty fell.
  - Expect exactly one reqFifo pulse.
- Route sweep, each with immediate grant:
  - 0x5000_0000 -> 00001 (Local)
  - 0x7000_0000 -> 00010 (North)
  - 0x4000_0000 -> 01000 (South)
  - 0x0000_0000 -> 10000 (West)
- Arbitration stall, route East:
  - gntSw=5'b00010 for 4 cycles -> reqSw stays 00100, validOut=0.
  - Then gntSw=00100 -> SEND next cycle.
  - With INCTR_STATS_EN: stallCycles=4 and pktCount=1 afterwards.
- FIFO non-grant: fifoEmpty=0 but gntFifo held 0 -> the FSM cycles IDLE->REQ->WAIT->IDLE; no validOut, no reqSw.
- Reset asserted while in ARB with reqSw=00100 -> the next cycle has every output 0 and state IDLE. A fresh flit after reset routes correctly.
- Back-to-back: 3 flits queued, grants immediate -> 3 reqFifo pulses spaced 6 cycles apart and 3 validOut pulses in order. With INCTR_STATS_EN, pktCount=3.

Source files
------------

// File: rtl/noc_pkg.sv
// noc_pkg: shared port indices, input-controller state encoding and flit destination helpers
package noc_pkg;
  localparam int PORT_L = 0;
  localparam int PORT_N = 1;
  localparam int PORT_E = 2;
  localparam int PORT_S = 3;
  localparam int PORT_W = 4;
  localparam int NUM_PORTS = 5;
  typedef logic [NUM_PORTS-1:0] portVecT;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, ROUTE, ARB, SEND} stateT;
  // Flits are zero-extended to 64 bits; destination fields are at most 8 bits wide.
  function automatic logic [7:0] getDestX(input logic [63:0] flit, input int dataWidth, input int dim);
    return 8'((flit >> (dataWidth - dim)) & ((64'd1 << dim) - 64'd1));
  endfunction
  function automatic logic [7:0] getDestY(input logic [63:0] flit, input int dataWidth, input int dim);
    return 8'((flit >> (dataWidth - 2 * dim)) & ((64'd1 << dim) - 64'd1));
  endfunction
endpackage

// File: rtl/xy_route_calc.sv
// xy_route_calc: combinational XY dimension-order route to a one-hot output port
// Ports: destX/destY flit destination, curX/curY this router, route one-hot {W,S,E,N,L}.
module xy_route_calc
  import noc_pkg::*;
#(
  parameter int dim = 2
) (
  input  logic [dim-1:0] destX,
  input  logic [dim-1:0] destY,
  input  logic [dim-1:0] curX,
  input  logic [dim-1:0] curY,
  output portVecT        route
);
  always_comb
    route = destX > curX ? portVecT'(1 << PORT_E) :
            destX < curX ? portVecT'(1 << PORT_W) :
            destY > curY ? portVecT'(1 << PORT_N) :
            destY < curY ? portVecT'(1 << PORT_S) :
                           portVecT'(1 << PORT_L);
endmodule

// File: rtl/input_controller.sv
// input_controller: pops one flit from the input FIFO, XY-routes it, arbitrates and sends it to the crossbar
// Ports: clk, reset (sync, active-high); fifoEmpty/reqFifo/gntFifo/PacketIn FIFO pop handshake;
// reqSw/gntSw one-hot switch-allocator handshake; PacketOut/validOut crossbar output.
// Build option INCTR_STATS_EN adds pktCount (wrapping sent-flit count) and stallCycles (saturating ARB stall count).
module input_controller
  import noc_pkg::*;
#(
  parameter int dataWidth = 32,
  parameter int dim = 2,
  parameter logic [dim-1:0] curX = dim'(1),
  parameter logic [dim-1:0] curY = dim'(1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fifoEmpty,
  output logic                 reqFifo,
  input  logic                 gntFifo,
  input  logic [dataWidth-1:0] PacketIn,
  output portVecT              reqSw,
  input  portVecT              gntSw,
  output logic [dataWidth-1:0] PacketOut,
  output logic                 validOut
`ifdef INCTR_STATS_EN
  ,
  output logic [15:0]          pktCount,
  output logic [15:0]          stallCycles
`endif
);
  stateT state;
  logic [dataWidth-1:0] flitReg;
  portVecT route, nextRoute;
  logic [dim-1:0] destX, destY;
  assign destX = dim'(getDestX(64'(flitReg), dataWidth, dim));
  assign destY = dim'(getDestY(64'(flitReg), dataWidth, dim));
  xy_route_calc #(.dim(dim)) routeCalc (
    .destX(destX),
    .destY(destY),
    .curX (curX),
    .curY (curY),
    .route(nextRoute)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      reqFifo   <= 1'b0;
      reqSw     <= '0;
      validOut  <= 1'b0;
      PacketOut <= '0;
      flitReg   <= '0;
      route     <= '0;
    end else begin
      reqFifo  <= 1'b0;
      validOut <= 1'b0;
      case (state)
        IDLE: if (!fifoEmpty) begin
          state   <= REQ;
          reqFifo <= 1'b1;
        end
        REQ: state <= WAIT;
        // A missing grant abandons the attempt; IDLE re-checks fifoEmpty.
        WAIT: begin
          if (gntFifo) flitReg <= PacketIn;
          state <= gntFifo ? ROUTE : IDLE;
        end
        ROUTE: begin
          route <= nextRoute;
          reqSw <= nextRoute;
          state <= ARB;
        end
        ARB: if ((gntSw & route) != '0) begin
          reqSw     <= '0;
          validOut  <= 1'b1;
          PacketOut <= flitReg;
          state     <= SEND;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef INCTR_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      pktCount    <= '0;
      stallCycles <= '0;
    end else begin
      if (state == SEND) pktCount <= pktCount + 16'd1;
      if (state == ARB && (gntSw & route) == '0 && stallCycles != 16'hFFFF) stallCycles <= stallCycles + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_input_controller.sv
// tb_input_controller: randomized self-checking bench for input_controller with a FIFO model and XY route reference
module tb_input_controller;
  import noc_pkg::*;
  logic clk = 1'b0, reset = 1'b1, fifoEmpty = 1'b1, gntFifo = 1'b0;
  logic reqFifo, validOut;
  logic [31:0] PacketIn = '0, PacketOut;
  logic [4:0] reqSw, gntSw = '0;
`ifdef INCTR_STATS_EN
  logic [15:0] pktCount, stallCycles;
`endif
  int passCnt = 0, totalCnt = 0, cyc = 0, pktModel = 0, stallModel = 0;
  bit allowGnt = 1'b1, lastReq = 1'b0;
  logic [31:0] fifoQ[$];

  always #5 clk = ~clk;

  input_controller #(.dataWidth(32), .dim(2), .curX(2'd1), .curY(2'd1)) dut (
    .clk(clk), .reset(reset), .fifoEmpty(fifoEmpty), .reqFifo(reqFifo), .gntFifo(gntFifo),
    .PacketIn(PacketIn), .reqSw(reqSw), .gntSw(gntSw), .PacketOut(PacketOut), .validOut(validOut)
`ifdef INCTR_STATS_EN
    , .pktCount(pktCount), .stallCycles(stallCycles)
`endif
  );

  function automatic logic [4:0] refRoute(input logic [31:0] f);
    int dx, dy;
    dx = int'(f >> 30);
    dy = int'((f >> 28) & 32'h3);
    if (dx != 1) return dx > 1 ? 5'b00100 : 5'b10000;
    if (dy != 1) return dy > 1 ? 5'b00010 : 5'b01000;
    return 5'b00001;
  endfunction

  // One clock step: sample point at negedge; the FIFO model grants the cycle after a request.
  task automatic tick();
    @(negedge clk);
    cyc++;
    gntFifo = lastReq && allowGnt && fifoQ.size() > 0;
    PacketIn = gntFifo ? fifoQ.pop_front() : $urandom;
    lastReq = reqFifo;
    fifoEmpty = fifoQ.size() == 0;
  endtask

  task automatic sendFlit(input logic [31:0] flit, input int stall, input logic [4:0] badGnt, input bit allOnes,
                          output logic [4:0] route, output int lat, output logic [31:0] data,
                          output int pulses, output bit steady);
    int t0;
    fifoQ.push_back(flit);
    gntSw = '0; route = '0; lat = -1; data = '0; pulses = 0; steady = 1'b1;
    tick();
    t0 = cyc;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (reqFifo) pulses++;
      if (validOut) begin
        lat = cyc - t0;
        data = PacketOut;
        break;
      end
      if (reqSw != '0) begin
        if (route != '0 && reqSw !== route) steady = 1'b0;
        route = reqSw;
        if (stall > 0) begin
          gntSw = badGnt != '0 ? badGnt : 5'($urandom) & ~reqSw;
          stall--;
        end else gntSw = allOnes ? 5'b11111 : reqSw | 5'($urandom);
      end else gntSw = '0;
    end
    gntSw = '0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    totalCnt++; if (reqFifo !== 1'b0) $display("FAIL reset_reqFifo: got %b expected 0", reqFifo); else passCnt++;
    totalCnt++; if (reqSw !== 5'b0) $display("FAIL reset_reqSw: got %b expected 00000", reqSw); else passCnt++;
    totalCnt++; if (validOut !== 1'b0) $display("FAIL reset_validOut: got %b expected 0", validOut); else passCnt++;
    totalCnt++; if (PacketOut !== 32'h0) $display("FAIL reset_PacketOut: got %h expected 0", PacketOut); else passCnt++;
`ifdef INCTR_STATS_EN
    totalCnt++; if (pktCount !== 16'h0) $display("FAIL reset_pktCount: got %0d expected 0", pktCount); else passCnt++;
    totalCnt++; if (stallCycles !== 16'h0) $display("FAIL reset_stallCycles: got %0d expected 0", stallCycles); else passCnt++;
`endif
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [4:0] r; int lat, pulses; logic [31:0] d; bit st;
    sendFlit(32'hC000_0000, 0, 5'b0, 1'b1, r, lat, d, pulses, st);
    pktModel++;
    totalCnt++; if (r !== 5'b00100) $display("FAIL basic_route: got %b expected 00100", r); else passCnt++;
    totalCnt++; if (lat !== 5) $display("FAIL basic_latency: got %0d expected 5", lat); else passCnt++;
    totalCnt++; if (d !== 32'hC000_0000) $display("FAIL basic_data: got %h expected c0000000", d); else passCnt++;
    totalCnt++; if (pulses !== 1) $display("FAIL basic_reqFifo_pulses: got %0d expected 1", pulses); else passCnt++;
    totalCnt++; if (validOut !== 1'b0) $display("FAIL basic_valid_one_cycle: got %b expected 0", validOut); else passCnt++;
  endtask

  task automatic test_route_sweep();
    logic [31:0] flits[4] = '{32'h5000_0000, 32'h7000_0000, 32'h4000_0000, 32'h0000_0000};
    logic [4:0] exp[4] = '{5'b00001, 5'b00010, 5'b01000, 5'b10000};
    logic [4:0] r; int lat, pulses; logic [31:0] d; bit st;
    for (int i = 0; i < 4; i++) begin
      sendFlit(flits[i], 0, 5'b0, 1'b1, r, lat, d, pulses, st);
      pktModel++;
      totalCnt++; if (r !== exp[i]) $display("FAIL sweep_route[%0d]: got %b expected %b", i, r, exp[i]); else passCnt++;
      totalCnt++; if (lat !== 5) $display("FAIL sweep_latency[%0d]: got %0d expected 5", i, lat); else passCnt++;
      totalCnt++; if (d !== flits[i]) $display("FAIL sweep_data[%0d]: got %h expected %h", i, d, flits[i]); else passCnt++;
    end
  endtask

  task automatic test_arb_stall();
    logic [4:0] r; int lat, pulses; logic [31:0] d; bit st;
    sendFlit(32'hC123_4567, 4, 5'b00010, 1'b0, r, lat, d, pulses, st);
    pktModel++;
    stallModel += 4;
    totalCnt++; if (r !== 5'b00100) $display("FAIL stall_route: got %b expected 00100", r); else passCnt++;
    totalCnt++; if (st !== 1'b1) $display("FAIL stall_reqSw_held: got %b expected 1", st); else passCnt++;
    totalCnt++; if (lat !== 9) $display("FAIL stall_latency: got %0d expected 9", lat); else passCnt++;
    totalCnt++; if (d !== 32'hC123_4567) $display("FAIL stall_data: got %h expected c1234567", d); else passCnt++;
`ifdef INCTR_STATS_EN
    totalCnt++; if (stallCycles !== 16'(stallModel)) $display("FAIL stall_stallCycles: got %0d expected %0d", stallCycles, stallModel); else passCnt++;
    totalCnt++; if (pktCount !== 16'(pktModel)) $display("FAIL stall_pktCount: got %0d expected %0d", pktCount, pktModel); else passCnt++;
`endif
  endtask

  task automatic test_random();
    logic [4:0] r; int lat, pulses, stall; logic [31:0] d, f; bit st;
    for (int i = 0; i < 10; i++) begin
      f = $urandom;
      stall = $urandom_range(0, 3);
      sendFlit(f, stall, 5'b0, 1'b0, r, lat, d, pulses, st);
      pktModel++;
      stallModel += stall;
      totalCnt++; if (r !== refRoute(f)) $display("FAIL rand_route[%0d]: got %b expected %b", i, r, refRoute(f)); else passCnt++;
      totalCnt++; if (lat !== 5 + stall) $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, lat, 5 + stall); else passCnt++;
      totalCnt++; if (d !== f) $display("FAIL rand_data[%0d]: got %h expected %h", i, d, f); else passCnt++;
    end
  endtask

  task automatic test_fifo_nogrant();
    int reqCyc[$]; bit sawValid = 1'b0, sawReqSw = 1'b0, spaced = 1'b1;
    allowGnt = 1'b0;
    fifoQ.push_back(32'hC000_0000);
    for (int i = 0; i < 30; i++) begin
      tick();
      if (reqFifo) reqCyc.push_back(cyc);
      if (validOut) sawValid = 1'b1;
      if (reqSw != '0) sawReqSw = 1'b1;
    end
    for (int i = 1; i < reqCyc.size(); i++) if (reqCyc[i] - reqCyc[i-1] != 3) spaced = 1'b0;
    totalCnt++; if (sawValid !== 1'b0) $display("FAIL nogrant_validOut: got %b expected 0", sawValid); else passCnt++;
    totalCnt++; if (sawReqSw !== 1'b0) $display("FAIL nogrant_reqSw: got %b expected 0", sawReqSw); else passCnt++;
    totalCnt++; if (reqCyc.size() < 8) $display("FAIL nogrant_retries: got %0d expected >=8", reqCyc.size()); else passCnt++;
    totalCnt++; if (spaced !== 1'b1) $display("FAIL nogrant_period: got %b expected 1", spaced); else passCnt++;
    fifoQ.delete();
    allowGnt = 1'b1;
    repeat (5) tick();
  endtask

  task automatic test_reset_in_arb();
    logic [4:0] r; int lat, pulses; logic [31:0] d; bit st, inArb = 1'b0, sawValid = 1'b0;
    fifoQ.push_back(32'hC000_0000);
    gntSw = '0;
    for (int i = 0; i < 20 && !inArb; i++) begin
      tick();
      inArb = reqSw === 5'b00100;
    end
    totalCnt++; if (inArb !== 1'b1) $display("FAIL rstarb_reach_arb: got %b expected 1", inArb); else passCnt++;
    reset = 1'b1;
    tick();
    totalCnt++; if (reqSw !== 5'b0) $display("FAIL rstarb_reqSw: got %b expected 00000", reqSw); else passCnt++;
    totalCnt++; if (validOut !== 1'b0 || reqFifo !== 1'b0) $display("FAIL rstarb_valid_req: got %b%b expected 00", validOut, reqFifo); else passCnt++;
    totalCnt++; if (PacketOut !== 32'h0) $display("FAIL rstarb_PacketOut: got %h expected 0", PacketOut); else passCnt++;
    totalCnt++; if (dut.state !== IDLE) $display("FAIL rstarb_state: got %0d expected %0d", dut.state, IDLE); else passCnt++;
    pktModel = 0;
    stallModel = 0;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (validOut) sawValid = 1'b1;
    end
    totalCnt++; if (sawValid !== 1'b0) $display("FAIL rstarb_dropped: got %b expected 0", sawValid); else passCnt++;
    sendFlit(32'h0ABC_1234, 0, 5'b0, 1'b0, r, lat, d, pulses, st);
    pktModel++;
    totalCnt++; if (r !== 5'b10000) $display("FAIL rstarb_fresh_route: got %b expected 10000", r); else passCnt++;
    totalCnt++; if (lat !== 5 || d !== 32'h0ABC_1234) $display("FAIL rstarb_fresh_send: got lat %0d data %h expected lat 5 data 0abc1234", lat, d); else passCnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] expQ[$]; logic [31:0] f; int reqCyc[$]; int got = 0; bit spaced = 1'b1;
    for (int i = 0; i < 3; i++) begin
      f = $urandom;
      fifoQ.push_back(f);
      expQ.push_back(f);
    end
    gntSw = '0;
    for (int i = 0; i < 60 && got < 3; i++) begin
      tick();
      if (reqFifo) reqCyc.push_back(cyc);
      if (validOut) begin
        f = expQ.pop_front();
        got++;
        pktModel++;
        totalCnt++; if (PacketOut !== f) $display("FAIL b2b_data[%0d]: got %h expected %h", got, PacketOut, f); else passCnt++;
      end
      gntSw = reqSw != '0 ? 5'b11111 : 5'b0;
    end
    gntSw = '0;
    repeat (3) tick();
    for (int i = 1; i < reqCyc.size(); i++) if (reqCyc[i] - reqCyc[i-1] != 6) spaced = 1'b0;
    totalCnt++; if (got !== 3) $display("FAIL b2b_count: got %0d expected 3", got); else passCnt++;
    totalCnt++; if (reqCyc.size() !== 3) $display("FAIL b2b_req_pulses: got %0d expected 3", reqCyc.size()); else passCnt++;
    totalCnt++; if (spaced !== 1'b1) $display("FAIL b2b_req_spacing: got %b expected 1", spaced); else passCnt++;
`ifdef INCTR_STATS_EN
    totalCnt++; if (pktCount !== 16'(pktModel)) $display("FAIL b2b_pktCount: got %0d expected %0d", pktCount, pktModel); else passCnt++;
    totalCnt++; if (stallCycles !== 16'(stallModel)) $display("FAIL b2b_stallCycles: got %0d expected %0d", stallCycles, stallModel); else passCnt++;
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_route_sweep();
    test_arb_stall();
    test_random();
    test_fifo_nogrant();
    test_reset_in_arb();
    test_back_to_back();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule
